// File: rtl/ram_pkg.sv
// Shared types and defaults for the RAM access controller and its cell array.
// The enum is one-hot, so any corrupted state value is caught by the controller's default arm.
package ram_pkg;

   localparam int RAM_DATA_W = 8;
   localparam int RAM_ADDR_W = 4;

   typedef enum logic [4:0] {
      RAM_ST_IDLE   = 5'b00001,
      RAM_ST_WRITE  = 5'b00010,
      RAM_ST_READ   = 5'b00100,
      RAM_ST_RESP   = 5'b01000,
      RAM_ST_VERIFY = 5'b10000
   } ram_state_t;

endpackage

// File: rtl/ram_cell_array.sv
// DATA_W x 2**ADDR_W cell array with per-word write decode and a combinational read port.
// STUCK0_MASK models stuck-at-0 cells; bits set in it never store a 1.
module ram_cell_array
   import ram_pkg::*;
#(
   parameter int                 DATA_W      = RAM_DATA_W,
   parameter int                 ADDR_W      = RAM_ADDR_W,
   parameter logic [DATA_W-1:0]  STUCK0_MASK = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              write_en,
   input  logic              read_en,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] write_data,
   output logic [DATA_W-1:0] read_data
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] words [DEPTH];

   for (genvar w = 0; w < DEPTH; w++) begin : g_word
      logic [DATA_W-1:0] word_q, word_d;

      always_comb begin
         word_d = word_q;
         if (write_en && (addr == ADDR_W'(w))) word_d = write_data & ~STUCK0_MASK;
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) word_q <= '0;
         else        word_q <= word_d;
      end

      assign words[w] = word_q;
   end

   assign read_data = read_en ? words[addr] : '0;

endmodule

// File: rtl/ram_access_ctrl.sv
// Request-side controller for the RAM cell array: one request in flight, single-cycle strobes.
// Define RAM_READBACK_EN to add a VERIFY cycle after each write and a sticky wr_err flag.
module ram_access_ctrl
   import ram_pkg::*;
#(
   parameter int DATA_W = RAM_DATA_W,
   parameter int ADDR_W = RAM_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              mem_write_en,
   output logic              mem_read_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_write_data,
   input  logic [DATA_W-1:0] mem_read_data,
   output logic              wr_err
);

   ram_state_t        state_q, state_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
`ifdef RAM_READBACK_EN
   logic              wr_err_q, wr_err_d;
`endif

   always_comb begin
      state_d      = state_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      rsp_rdata_d  = rsp_rdata_q;
`ifdef RAM_READBACK_EN
      wr_err_d     = wr_err_q;
`endif
      req_ready    = 1'b0;
      rsp_valid    = 1'b0;
      mem_write_en = 1'b0;
      mem_read_en  = 1'b0;
      case (state_q)
         RAM_ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               mem_addr_d  = req_addr;
               mem_wdata_d = req_wdata;
               state_d     = req_we ? RAM_ST_WRITE : RAM_ST_READ;
            end
         end
         RAM_ST_WRITE: begin
            mem_write_en = 1'b1;
`ifdef RAM_READBACK_EN
            state_d      = RAM_ST_VERIFY;
`else
            state_d      = RAM_ST_IDLE;
`endif
         end
         RAM_ST_READ: begin
            mem_read_en = 1'b1;
            rsp_rdata_d = mem_read_data;
            state_d     = RAM_ST_RESP;
         end
         RAM_ST_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_d = RAM_ST_IDLE;
         end
`ifdef RAM_READBACK_EN
         RAM_ST_VERIFY: begin
            // Same address is still on mem_addr, so the array returns what was just stored.
            mem_read_en = 1'b1;
            if (mem_read_data != mem_wdata_q) wr_err_d = 1'b1;
            state_d     = RAM_ST_IDLE;
         end
`endif
         default: state_d = RAM_ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RAM_ST_IDLE;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

`ifdef RAM_READBACK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) wr_err_q <= 1'b0;
      else        wr_err_q <= wr_err_d;
   end
   assign wr_err = wr_err_q;
`else
   assign wr_err = 1'b0;
`endif

   assign mem_addr       = mem_addr_q;
   assign mem_write_data = mem_wdata_q;
   assign rsp_rdata      = rsp_rdata_q;

endmodule
